// File: rtl/spi_operand_link.sv
// spi_operand_link: SPI mode-0 slave that receives an 8-bit frame
// {cmd[3:0], operand[3:0]} and returns {result, flags}. It updates the ALU
// operand on a write command and reports rejected or short frames.
module spi_operand_link #(
  parameter logic [3:0]  CMD_WRITE   = 4'h1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_in,
  input  logic       mosi_in,
  input  logic       ss_n_in,
  input  logic [3:0] result_in,
  input  logic [3:0] flags_in,
  output logic       miso_out,
  output logic [3:0] operand_out,
  output logic       operand_valid,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
  logic       sclk_d, ss_d;
  logic       sclk_s, mosi_s, ss_s;
  logic       sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift, tx_shift, rx_next;
  logic       load_tx, shift_rx, shift_tx, eval, abort;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_fall   = ~ss_s & ss_d;
  assign ss_rise   = ss_s & ~ss_d;
  assign rx_next   = {rx_shift[6:0], mosi_s};
  assign miso_out  = (state == SHIFT && !ss_s) ? tx_shift[7] : 1'b0;

  // Synchronizer chains plus one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n_in};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state and datapath strobes; a slave-select rise aborts a partial
  // frame even if an sclk edge lands in the same cycle
  always_comb begin
    state_next = state;
    load_tx    = 1'b0;
    shift_rx   = 1'b0;
    shift_tx   = 1'b0;
    eval       = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_next = SHIFT;
          load_tx    = 1'b1;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else begin
          if (sclk_rise) begin
            shift_rx = 1'b1;
            if (bit_cnt == 3'd7) begin
              eval       = 1'b1;
              state_next = HOLD;
            end
          end
          if (sclk_fall) shift_tx = 1'b1;
        end
      end
      HOLD: begin
        if (ss_rise) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift registers, bit counter, operand register and result pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt       <= '0;
      rx_shift      <= '0;
      tx_shift      <= '0;
      operand_out   <= '0;
      operand_valid <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      operand_valid <= 1'b0;
      frame_err     <= 1'b0;
      if (load_tx) begin
        tx_shift <= {result_in, flags_in};
        bit_cnt  <= '0;
        rx_shift <= '0;
      end
      if (shift_tx) tx_shift <= {tx_shift[6:0], 1'b0};
      if (shift_rx) begin
        rx_shift <= rx_next;
        // the counter stops at 7 on the last bit instead of wrapping
        if (!eval) bit_cnt <= bit_cnt + 3'd1;
      end
      if (eval) begin
        if (rx_next[7:4] == CMD_WRITE) begin
          operand_out   <= rx_next[3:0];
          operand_valid <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end
      if (abort) begin
        rx_shift  <= '0;
        frame_err <= 1'b1;
      end
    end
  end

endmodule
